lsu_align_ctrl: RTL and testbench

- Sequential load/store alignment controller between the core's memory stage and a word-wide data memory port.
- Performs byte/half/word loads and stores with sign/zero extension and byte-lane masking.
- Uses a valid/ready request handshake and a grant/rvalid memory handshake.
- Splits accesses that straddle a word boundary into two memory beats, and optionally reports memory timeouts.

---
 rtl/lsu_align_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_lsu_align_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: byte/half/word accesses onto a word-wide memory port.
// Define LSU_MISALIGN_SPLIT_EN to run word-straddling accesses as two beats instead of rejecting them.
module lsu_align_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned TO_LIM = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int unsigned LANE_W = 64;
`else
    localparam int unsigned LANE_W = 32;
`endif
    localparam int unsigned MASK_W = LANE_W / 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_WAIT0 = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
        S_BEAT1 = 3'd3,
        S_WAIT1 = 3'd4,
`endif
        S_RESP  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [31:0]         wdata_q;
    logic [31:0]         lo_q, lo_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0]         hi_q, hi_d;
    logic                split_q;
`endif
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept;
    logic [ADDR_W-1:0]   addr_n, base_n;
    logic                we_n;
    logic [2:0]          f3_n;
    logic [31:0]         wdata_n;
    logic [1:0]          off_n;
    logic [2:0]          nbytes;
    logic [3:0]          nmask;
    logic [31:0]         lane_data;
    logic                split_n, illegal_n, reject_n;
    logic [LANE_W-1:0]   store_s;
    logic [MASK_W-1:0]   store_m;
    logic                timeout, err_d;
    logic [31:0]         ld_word, ld_res;

    logic                req_ready_d, mem_req_d, mem_we_d, rsp_valid_d, rsp_err_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [31:0]         mem_wdata_d, rsp_rdata_d;
    logic [3:0]          mem_wmask_d;

    assign accept  = req_valid & req_ready;
    assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TO_LIM));

    // Request fields as they will be after this edge, plus size decode and store lane placement.
    always_comb begin
        addr_n    = accept ? req_addr   : addr_q;
        we_n      = accept ? req_we     : we_q;
        f3_n      = accept ? req_funct3 : f3_q;
        wdata_n   = accept ? req_wdata  : wdata_q;
        off_n     = addr_n[1:0];
        base_n    = {addr_n[ADDR_W-1:2], 2'b00};
        nbytes    = 3'd0;
        nmask     = 4'b0000;
        lane_data = '0;
        case (f3_n[1:0])
            2'b00: begin
                nbytes    = 3'd1;
                nmask     = 4'b0001;
                lane_data = {24'b0, wdata_n[7:0]};
            end
            2'b01: begin
                nbytes    = 3'd2;
                nmask     = 4'b0011;
                lane_data = {16'b0, wdata_n[15:0]};
            end
            2'b10: begin
                nbytes    = 3'd4;
                nmask     = 4'b1111;
                lane_data = wdata_n;
            end
            default: ;
        endcase
        split_n   = (4'(off_n) + 4'(nbytes)) > 4'd4;
        illegal_n = we_n ? (f3_n[2] | (f3_n[1:0] == 2'b11))
                         : ((f3_n == 3'b011) | (f3_n[2:1] == 2'b11));
`ifdef LSU_MISALIGN_SPLIT_EN
        reject_n  = illegal_n;
        store_s   = 64'(lane_data) << {off_n, 3'b000};
        store_m   = 8'(nmask) << off_n;
`else
        reject_n  = illegal_n | split_n;
        store_s   = lane_data << {off_n, 3'b000};
        store_m   = nmask << off_n;
`endif
    end

    // Next-state, watchdog, load extension and next registered outputs.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        lo_d    = accept ? '0 : lo_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        hi_d    = accept ? '0 : hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (reject_n) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_BEAT0;
                    end
                end
            end
            S_BEAT0: begin
                if (mem_gnt) begin
                    if (!we_q)        state_d = S_WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    else if (split_q) state_d = S_BEAT1;
`endif
                    else              state_d = S_RESP;
                end else if (timeout) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
            S_WAIT0: begin
                if (mem_rvalid) begin
                    lo_d = mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_d = split_q ? S_BEAT1 : S_RESP;
`else
                    state_d = S_RESP;
`endif
                end else if (timeout) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_BEAT1: begin
                if (mem_gnt) begin
                    state_d = we_q ? S_RESP : S_WAIT1;
                end else if (timeout) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
                    hi_d    = mem_rdata;
                    state_d = S_RESP;
                end else if (timeout) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((state_d != state_q) || (state_d == S_IDLE) || (state_d == S_RESP))
            cnt_d = '0;
        else
            cnt_d = cnt_q + CNT_W'(1);

`ifdef LSU_MISALIGN_SPLIT_EN
        ld_word = 32'({hi_d, lo_d} >> {off_n, 3'b000});
`else
        ld_word = lo_d >> {off_n, 3'b000};
`endif
        case (f3_n)
            3'b000:  ld_res = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_res = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_res = {24'b0, ld_word[7:0]};
            3'b101:  ld_res = {16'b0, ld_word[15:0]};
            default: ld_res = ld_word;
        endcase

        req_ready_d = (state_d == S_IDLE);
        mem_req_d   = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wmask_d = '0;
        if (state_d == S_BEAT0) begin
            mem_req_d  = 1'b1;
            mem_addr_d = base_n;
            if (we_n) begin
                mem_wdata_d = store_s[31:0];
                mem_wmask_d = store_m[3:0];
            end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state_d == S_BEAT1) begin
            mem_req_d  = 1'b1;
            mem_addr_d = base_n + ADDR_W'(4);
            if (we_n) begin
                mem_wdata_d = store_s[63:32];
                mem_wmask_d = store_m[7:4];
            end
        end
`endif
        mem_we_d    = mem_req_d & we_n;
        rsp_valid_d = (state_d == S_RESP);
        rsp_err_d   = err_d;
        rsp_rdata_d = (rsp_valid_d && !we_n && !err_d) ? ld_res : '0;
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            wdata_q   <= '0;
            lo_q      <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            hi_q      <= '0;
            split_q   <= 1'b0;
`endif
            cnt_q     <= '0;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                f3_q    <= req_funct3;
                wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
                split_q <= split_n;
`endif
            end
            lo_q      <= lo_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            hi_q      <= hi_d;
`endif
            cnt_q     <= cnt_d;
            req_ready <= req_ready_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_wmask <= mem_wmask_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Directed self-checking bench for lsu_align_ctrl (watchdog set to 8 cycles).
// Split-access expectations follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_align_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    logic        gnt_en;
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic [31:0] w100, w104;

    logic [7:0]  b_cnt;
    logic        b_we    [256];
    logic [31:0] b_addr  [256];
    logic [31:0] b_wdata [256];
    logic [3:0]  b_wmask [256];

    int          n_err, n_chk;
    int          lat, mreq_cyc;
    logic        got, er;
    logic [31:0] rd;
    logic [7:0]  b0;

    lsu_align_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Two-word memory: grant while enabled, read data one cycle after grant; log every granted beat.
    assign mem_gnt    = mem_req & gnt_en;
    assign mem_rvalid = rvalid_r;
    assign mem_rdata  = rdata_r;

    always @(posedge clk) begin
        rvalid_r <= mem_req && mem_gnt && !mem_we;
        rdata_r  <= mem_addr[2] ? w104 : w100;
        if (mem_req && mem_gnt) begin
            b_we[b_cnt]    <= mem_we;
            b_addr[b_cnt]  <= mem_addr;
            b_wdata[b_cnt] <= mem_wdata;
            b_wmask[b_cnt] <= mem_wmask;
            b_cnt          <= b_cnt + 8'd1;
        end
    end

    task automatic run_access(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        b0 = b_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0; got = 1'b0; mreq_cyc = 0; rd = 'x; er = 1'bx;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_req) mreq_cyc++;
            if (rsp_valid) begin got = 1'b1; rd = rsp_rdata; er = rsp_err; end
        end
        n_chk++;
        if (!got) begin n_err++; $display("FAIL %s_rsp: no rsp_valid after %0d cycles", name, lat); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_chk++;
        if ({mem_req, mem_we, mem_wmask, rsp_valid, rsp_err} !== 8'h00) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000000", {mem_req, mem_we, mem_wmask, rsp_valid, rsp_err});
        end
        n_chk++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== 96'h0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h want 0", mem_addr, mem_wdata, rsp_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_aligned_lw();
        w100 = 32'hDEADBEEF;
        run_access("lw", 1'b0, 3'b010, 32'h100, 32'h0);
        n_chk++;
        if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
        n_chk++;
        if (er !== 1'b0) begin n_err++; $display("FAIL lw_err: got %b want 0", er); end
        n_chk++;
        if (lat !== 3) begin n_err++; $display("FAIL lw_latency: got %0d want 3", lat); end
        n_chk++;
        if (8'(b_cnt - b0) !== 8'd1 || b_addr[b0] !== 32'h100 || b_we[b0] !== 1'b0) begin
            n_err++; $display("FAIL lw_beat: got n=%0d addr=%h we=%b want n=1 addr=00000100 we=0",
                              8'(b_cnt - b0), b_addr[b0], b_we[b0]);
        end
    endtask

    task automatic test_sub_word_loads();
        w100 = 32'h80FF0000;
        run_access("lb", 1'b0, 3'b000, 32'h103, 32'h0);
        n_chk++;
        if (rd !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_103: got %h want ffffff80", rd); end
        n_chk++;
        if (b_addr[b0] !== 32'h100) begin n_err++; $display("FAIL lb_addr: got %h want 00000100", b_addr[b0]); end
        run_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0);
        n_chk++;
        if (rd !== 32'h00000080) begin n_err++; $display("FAIL lbu_103: got %h want 00000080", rd); end
        run_access("lh", 1'b0, 3'b001, 32'h102, 32'h0);
        n_chk++;
        if (rd !== 32'hFFFF80FF) begin n_err++; $display("FAIL lh_102: got %h want ffff80ff", rd); end
        run_access("lhu", 1'b0, 3'b101, 32'h102, 32'h0);
        n_chk++;
        if (rd !== 32'h000080FF) begin n_err++; $display("FAIL lhu_102: got %h want 000080ff", rd); end
        run_access("lb2", 1'b0, 3'b000, 32'h102, 32'h0);
        n_chk++;
        if (rd !== 32'hFFFFFFFF) begin n_err++; $display("FAIL lb_102: got %h want ffffffff", rd); end
    endtask

    task automatic test_stores();
        run_access("sb", 1'b1, 3'b000, 32'h101, 32'hDEADBEAB);
        n_chk++;
        if (b_wmask[b0] !== 4'b0010 || b_wdata[b0] !== 32'h0000AB00 || b_we[b0] !== 1'b1) begin
            n_err++; $display("FAIL sb_beat: got mask=%b data=%h we=%b want 0010 0000ab00 1",
                              b_wmask[b0], b_wdata[b0], b_we[b0]);
        end
        n_chk++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin
            n_err++; $display("FAIL sb_rsp: got rdata=%h err=%b lat=%0d want 0 0 2", rd, er, lat);
        end
        run_access("sh", 1'b1, 3'b001, 32'h102, 32'h1234CDEF);
        n_chk++;
        if (b_wmask[b0] !== 4'b1100 || b_wdata[b0] !== 32'hCDEF0000 || b_addr[b0] !== 32'h100) begin
            n_err++; $display("FAIL sh_beat: got mask=%b data=%h addr=%h want 1100 cdef0000 00000100",
                              b_wmask[b0], b_wdata[b0], b_addr[b0]);
        end
        run_access("sw", 1'b1, 3'b010, 32'h104, 32'hCAFEF00D);
        n_chk++;
        if (b_wmask[b0] !== 4'b1111 || b_wdata[b0] !== 32'hCAFEF00D || b_addr[b0] !== 32'h104) begin
            n_err++; $display("FAIL sw_beat: got mask=%b data=%h addr=%h want 1111 cafef00d 00000104",
                              b_wmask[b0], b_wdata[b0], b_addr[b0]);
        end
    endtask

    task automatic test_split();
        w100 = 32'hAABBCCDD;
        w104 = 32'h11223344;
        run_access("lh_split", 1'b0, 3'b001, 32'h103, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        n_chk++;
        if (rd !== 32'h000044AA || er !== 1'b0 || lat !== 5) begin
            n_err++; $display("FAIL lh_split_rsp: got rdata=%h err=%b lat=%0d want 000044aa 0 5", rd, er, lat);
        end
        n_chk++;
        if (8'(b_cnt - b0) !== 8'd2 || b_addr[b0] !== 32'h100 || b_addr[8'(b0 + 8'd1)] !== 32'h104) begin
            n_err++; $display("FAIL lh_split_beats: got n=%0d a0=%h a1=%h want 2 00000100 00000104",
                              8'(b_cnt - b0), b_addr[b0], b_addr[8'(b0 + 8'd1)]);
        end
`else
        n_chk++;
        if (rd !== 32'h0 || er !== 1'b1 || lat !== 1 || mreq_cyc !== 0) begin
            n_err++; $display("FAIL lh_split_rsp: got rdata=%h err=%b lat=%0d mreq=%0d want 0 1 1 0",
                              rd, er, lat, mreq_cyc);
        end
`endif
        run_access("sw_split", 1'b1, 3'b010, 32'h102, 32'h12345678);
`ifdef LSU_MISALIGN_SPLIT_EN
        n_chk++;
        if (b_addr[b0] !== 32'h100 || b_wmask[b0] !== 4'b1100 || b_wdata[b0] !== 32'h56780000) begin
            n_err++; $display("FAIL sw_split_b0: got addr=%h mask=%b data=%h want 00000100 1100 56780000",
                              b_addr[b0], b_wmask[b0], b_wdata[b0]);
        end
        n_chk++;
        if (b_addr[8'(b0 + 8'd1)] !== 32'h104 || b_wmask[8'(b0 + 8'd1)] !== 4'b0011 ||
            b_wdata[8'(b0 + 8'd1)] !== 32'h00001234) begin
            n_err++; $display("FAIL sw_split_b1: got addr=%h mask=%b data=%h want 00000104 0011 00001234",
                              b_addr[8'(b0 + 8'd1)], b_wmask[8'(b0 + 8'd1)], b_wdata[8'(b0 + 8'd1)]);
        end
        n_chk++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
            n_err++; $display("FAIL sw_split_rsp: got rdata=%h err=%b lat=%0d want 0 0 3", rd, er, lat);
        end
`else
        n_chk++;
        if (er !== 1'b1 || 8'(b_cnt - b0) !== 8'd0 || mreq_cyc !== 0) begin
            n_err++; $display("FAIL sw_split_rsp: got err=%b beats=%0d mreq=%0d want 1 0 0",
                              er, 8'(b_cnt - b0), mreq_cyc);
        end
        run_access("lw_split", 1'b0, 3'b010, 32'h101, 32'h0);
        n_chk++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_err++; $display("FAIL lw_split_rsp: got err=%b rdata=%h want 1 0", er, rd);
        end
`endif
    endtask

    task automatic test_illegal();
        run_access("ld011", 1'b0, 3'b011, 32'h100, 32'h0);
        n_chk++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || mreq_cyc !== 0) begin
            n_err++; $display("FAIL ld011_rsp: got err=%b rdata=%h lat=%0d mreq=%0d want 1 0 1 0",
                              er, rd, lat, mreq_cyc);
        end
        run_access("ld111", 1'b0, 3'b111, 32'h100, 32'h0);
        n_chk++;
        if (er !== 1'b1 || mreq_cyc !== 0) begin
            n_err++; $display("FAIL ld111_rsp: got err=%b mreq=%0d want 1 0", er, mreq_cyc);
        end
        run_access("st100", 1'b1, 3'b100, 32'h100, 32'h55);
        n_chk++;
        if (er !== 1'b1 || mreq_cyc !== 0) begin
            n_err++; $display("FAIL st100_rsp: got err=%b mreq=%0d want 1 0", er, mreq_cyc);
        end
    endtask

    task automatic test_timeout();
        gnt_en = 1'b0;
        run_access("timeout", 1'b0, 3'b010, 32'h100, 32'h0);
        gnt_en = 1'b1;
        n_chk++;
        if (mreq_cyc !== 8) begin n_err++; $display("FAIL timeout_mreq: got %0d cycles want 8", mreq_cyc); end
        n_chk++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 9) begin
            n_err++; $display("FAIL timeout_rsp: got err=%b rdata=%h lat=%0d want 1 0 9", er, rd, lat);
        end
    endtask

    task automatic test_reset_mid_beat();
        logic seen;
        gnt_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            n_err++; $display("FAIL rstmid_pre: got req=%b addr=%h want 1 00000100", mem_req, mem_addr);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_async: got req=%b addr=%h ready=%b rsp=%b want 0 0 1 0",
                              mem_req, mem_addr, req_ready, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        gnt_en = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || mem_req) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet: got activity=%b want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic done;
        int   n;
        w100 = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 32'h100;
        @(posedge clk);
        #1;
        req_funct3 = 3'b010;
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_resp: got valid=%b err=%b ready=%b want 1 1 0",
                              rsp_valid, rsp_err, req_ready);
        end
        @(negedge clk);
        n_chk++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        done = 1'b0; n = 0; rd = 'x;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin done = 1'b1; rd = rsp_rdata; end
        end
        n_chk++;
        if (!done || n !== 3 || rd !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL b2b_second: got done=%b lat=%0d rdata=%h want 1 3 deadbeef", done, n, rd);
        end
    endtask

    initial begin
        n_err = 0; n_chk = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        gnt_en = 1'b1; w100 = '0; w104 = '0;
        b_cnt = '0; rvalid_r = 1'b0; rdata_r = '0;
        test_reset();
        test_aligned_lw();
        test_sub_word_loads();
        test_stores();
        test_split();
        test_illegal();
        test_timeout();
        test_reset_mid_beat();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
